// File: rtl/bus_deser_pkg.sv
// Shared types and defaults for the serial-to-parallel bus deserializer.
package bus_deser_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bus_deserializer.sv
// Serial-to-parallel front end with a valid/ready parallel bus, sticky overrun flag
// and optional even-parity checking (enabled by defining PARITY_CHECK_EN).
module bus_deserializer
  import bus_deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_clr,
  output logic [WIDTH-1:0] bus,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             bus_valid_q, bus_valid_d;
  logic             overrun_q, overrun_d;
  logic [CW-1:0]    bit_pos;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] load_word;
  logic             load_req;
`ifdef PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    bus_d       = bus_q;
    bus_valid_d = bus_valid_q;
    overrun_d   = overrun_q;
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    load_req    = 1'b0;
    load_word   = shreg_q;

    // The incoming bit lands at its final bus position, so no shifting is needed.
    bit_pos = (MSB_FIRST != 0) ? (LAST - cnt_q) : cnt_q;
    word_c  = shreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == bit_pos) word_c[i] = ser_in;
    end

    if (ser_clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      overrun_d = 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_d = 1'b0;
`endif
    end else if (ser_valid) begin
      case (state_q)
        IDLE, SHIFT: begin
          shreg_d = word_c;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d   = IDLE;
            load_req  = 1'b1;
            load_word = word_c;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          state_d = IDLE;
          if ((^shreg_q) ^ ser_in) begin
            parity_err_d = 1'b1;
          end else begin
            load_req  = 1'b1;
            load_word = shreg_q;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A completed word may only replace the bus if the pending one is gone or leaving now.
    if (load_req) begin
      if (!bus_valid_q || bus_ready) begin
        bus_d       = load_word;
        bus_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus_valid_q && bus_ready) begin
      bus_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_deserializer.sv
// Directed, table-driven bench for bus_deserializer (LSB-first and MSB-first instances).
module tb_bus_deserializer;

  logic       clk;
  logic       rst_n;
  logic       ser_in, ser_valid, ser_clr, bus_ready;
  logic [7:0] bus;
  logic       bus_valid, overrun, parity_err;
  logic       ser_in_m, ser_valid_m, ser_clr_m, bus_ready_m;
  logic [7:0] bus_m;
  logic       bus_valid_m, overrun_m, parity_err_m;

  int n_cmp = 0;
  int n_err = 0;

  bus_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_clr(ser_clr),
    .bus(bus), .bus_valid(bus_valid), .bus_ready(bus_ready), .overrun(overrun),
    .parity_err(parity_err)
  );

  bus_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in_m), .ser_valid(ser_valid_m), .ser_clr(ser_clr_m),
    .bus(bus_m), .bus_valid(bus_valid_m), .bus_ready(bus_ready_m), .overrun(overrun_m),
    .parity_err(parity_err_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] word;
    int         gap;
    logic       rdy;
    logic [7:0] exp_bus;
    logic       exp_vld;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic send_bit_l(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_bit_m(input logic b);
    ser_in_m    = b;
    ser_valid_m = 1'b1;
    @(posedge clk);
    #1;
    ser_valid_m = 1'b0;
  endtask

  // LSB-first bits lo..hi of w; the frame's parity bit follows bit 7 when parity is enabled.
  task automatic send_range_l(input logic [7:0] w, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      repeat (gap) idle_cycle();
      send_bit_l(w[i]);
    end
`ifdef PARITY_CHECK_EN
    if (hi == 7) begin
      repeat (gap) idle_cycle();
      send_bit_l(^w);
    end
`endif
  endtask

  task automatic send_word_m(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      repeat ((7 - i) % 4) idle_cycle();
      send_bit_m(w[i]);
    end
`ifdef PARITY_CHECK_EN
    send_bit_m(^w);
`endif
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, gap: 0, rdy: 1'b1, exp_bus: 8'hA5, exp_vld: 1'b1, exp_ovr: 1'b0};
    vecs[1] = '{word: 8'h3C, gap: 1, rdy: 1'b1, exp_bus: 8'h3C, exp_vld: 1'b1, exp_ovr: 1'b0};
    vecs[2] = '{word: 8'h11, gap: 2, rdy: 1'b0, exp_bus: 8'h3C, exp_vld: 1'b1, exp_ovr: 1'b1};
    vecs[3] = '{word: 8'hFF, gap: 0, rdy: 1'b1, exp_bus: 8'hFF, exp_vld: 1'b1, exp_ovr: 1'b1};

    rst_n = 1'b0;
    ser_in = 1'b0; ser_valid = 1'b0; ser_clr = 1'b0; bus_ready = 1'b0;
    ser_in_m = 1'b0; ser_valid_m = 1'b0; ser_clr_m = 1'b0; bus_ready_m = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_bus", 32'(bus), 32'h0);
    check("reset_valid", 32'(bus_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();

    for (int v = 0; v < 4; v++) begin
      bus_ready = vecs[v].rdy;
      send_range_l(vecs[v].word, 0, 7, vecs[v].gap);
      settle();
      check($sformatf("vec%0d_bus", v), 32'(bus), 32'(vecs[v].exp_bus));
      check($sformatf("vec%0d_valid", v), 32'(bus_valid), 32'(vecs[v].exp_vld));
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
    end

    // Asynchronous reset in the middle of a frame while a word is pending.
    bus_ready = 1'b0;
    send_range_l(8'h5A, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_bus", 32'(bus), 32'h0);
    check("midreset_valid", 32'(bus_valid), 32'h0);
    check("midreset_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    send_range_l(8'h96, 0, 7, 0);
    settle();
    check("postreset_bus", 32'(bus), 32'h96);
    check("postreset_valid", 32'(bus_valid), 32'h1);

    // Overrun while the consumer stalls, then cleared by ser_clr.
    send_range_l(8'h22, 0, 7, 0);
    settle();
    check("overrun_bus_held", 32'(bus), 32'h96);
    check("overrun_flag", 32'(overrun), 32'h1);
    ser_clr = 1'b1;
    idle_cycle();
    ser_clr = 1'b0;
    settle();
    check("clr_overrun", 32'(overrun), 32'h0);
    check("clr_keeps_valid", 32'(bus_valid), 32'h1);
    check("clr_keeps_bus", 32'(bus), 32'h96);

    // Load coinciding with accept.
    send_range_l(8'h22, 0, 6, 0);
    bus_ready = 1'b1;
    send_range_l(8'h22, 7, 7, 0);
    bus_ready = 1'b0;
    settle();
    check("loadaccept_bus", 32'(bus), 32'h22);
    check("loadaccept_valid", 32'(bus_valid), 32'h1);
    check("loadaccept_overrun", 32'(overrun), 32'h0);
    bus_ready = 1'b1;
    idle_cycle();
    settle();
    check("accept_clears_valid", 32'(bus_valid), 32'h0);

    // ser_clr beats a simultaneous ser_valid; the next frame must align from bit 0.
    send_range_l(8'hFF, 0, 2, 0);
    ser_clr = 1'b1;
    send_bit_l(1'b1);
    ser_clr = 1'b0;
    send_range_l(8'h81, 0, 6, 0);
    settle();
    check("clrwins_no_early_load", 32'(bus_valid), 32'h0);
    send_range_l(8'h81, 7, 7, 0);
    settle();
    check("clrwins_bus", 32'(bus), 32'h81);
    check("clrwins_valid", 32'(bus_valid), 32'h1);

    // MSB-first with irregular gaps.
    bus_ready_m = 1'b1;
    send_word_m(8'h3C);
    settle();
    check("msb_bus", 32'(bus_m), 32'h3C);
    check("msb_valid", 32'(bus_valid_m), 32'h1);
    check("msb_overrun", 32'(overrun_m), 32'h0);
    check("no_parity_err", 32'(parity_err), 32'h0);

`ifdef PARITY_CHECK_EN
    bus_ready = 1'b1;
    idle_cycle();
    send_range_l(8'h07, 0, 7, 0);
    settle();
    check("parity_good_bus", 32'(bus), 32'h07);
    check("parity_good_valid", 32'(bus_valid), 32'h1);
    idle_cycle();
    for (int i = 0; i < 8; i++) send_bit_l(i < 3);
    send_bit_l(1'b0);
    settle();
    check("parity_bad_flag", 32'(parity_err), 32'h1);
    check("parity_bad_bus", 32'(bus), 32'h07);
    check("parity_bad_no_load", 32'(bus_valid), 32'h0);
    check("parity_bad_no_overrun", 32'(overrun), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
